riscv_core_icache_axi_rd_master: RTL and testbench

//  AXI4 read-burst master that services I-cache line refills.
//  - Sits between the I-cache controller/memory and the system AXI interconnect.
//  - Takes a miss request (i_mem_req + address) and issues one INCR read burst.
//  - Packs the returned beats into one cache line.
//  - Returns the line with o_mem_done using a four-phase req/done handshake.

---
 rtl/riscv_core_icache_axi_rd_master.sv | 133 +++++++++++++
 tb/tb_riscv_core_icache_axi_rd_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_icache_axi_rd_master.sv
// I-cache refill master: turns a level miss request into one AXI4 INCR read burst,
// packs the returned beats into a cache line and answers with a four-phase done.
module riscv_core_icache_axi_rd_master #(
  parameter int ADDR_WIDTH     = 64,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int LINE_WIDTH     = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_mem_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic                      o_mem_done,
  output logic [LINE_WIDTH-1:0]     o_block,
  output logic                      o_bus_err,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast,
  input  logic                      i_rvalid,
  output logic                      o_rready
);

  localparam int BEATS      = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int LINE_BYTES = LINE_WIDTH / 8;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [CNT_W-1:0]        beat_cnt_r;
  logic [LINE_WIDTH-1:0]   block_r;
  logic [ADDR_WIDTH-1:0]   araddr_r;
  logic                    bus_err_r;
  logic                    arvalid_r;
  logic                    rready_r;
  logic                    done_r;
  logic                    accept_s;
  logic                    beat_ok_s;
  logic                    last_cnt_s;
  logic                    burst_end_s;

  assign accept_s    = (state_r == ST_IDLE) && i_mem_req;
  assign beat_ok_s   = (state_r == ST_R) && i_rvalid;
  assign last_cnt_s  = (beat_cnt_r == LAST_BEAT);
  // A burst ends on RLAST or on the final slot, whichever comes first.
  assign burst_end_s = beat_ok_s && (i_rlast || last_cnt_s);

  // Next-state decode for the refill sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_mem_req) state_nxt_s = ST_AR;
        else           state_nxt_s = ST_IDLE;
      end
      ST_AR: begin
        if (i_arready) state_nxt_s = ST_R;
        else           state_nxt_s = ST_AR;
      end
      ST_R: begin
        if (burst_end_s) state_nxt_s = ST_DONE;
        else             state_nxt_s = ST_R;
      end
      ST_DONE: begin
        if (!i_mem_req) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Handshake outputs registered from the next state so they track it exactly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      arvalid_r <= (state_nxt_s == ST_AR);
      rready_r  <= (state_nxt_s == ST_R);
      done_r    <= (state_nxt_s == ST_DONE);
    end
  end

  // Address latch, beat packing and sticky error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      araddr_r   <= {ADDR_WIDTH{1'b0}};
      block_r    <= {LINE_WIDTH{1'b0}};
      bus_err_r  <= 1'b0;
      beat_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      araddr_r  <= i_addr & ~OFF_MASK;
      bus_err_r <= 1'b0;
    end else if (beat_ok_s) begin
      block_r[beat_cnt_r*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
      // RLAST must coincide with the final slot; any mismatch is a protocol error.
      if ((i_rresp != 2'b00) || (i_rlast != last_cnt_s)) bus_err_r <= 1'b1;
      if (burst_end_s) beat_cnt_r <= {CNT_W{1'b0}};
      else             beat_cnt_r <= beat_cnt_r + CNT_W'(1);
    end
  end

  assign o_mem_done = done_r;
  assign o_block    = block_r;
  assign o_bus_err  = bus_err_r;
  assign o_araddr   = araddr_r;
  assign o_arvalid  = arvalid_r;
  assign o_rready   = rready_r;
  assign o_arlen    = 8'(BEATS - 1);
  assign o_arsize   = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_arburst  = 2'b01;

endmodule

// File: tb/tb_riscv_core_icache_axi_rd_master.sv
// Directed bench for the I-cache AXI refill master: one task per scenario, inline checks.
module tb_riscv_core_icache_axi_rd_master;

  logic         clk;
  logic         rst_n;
  logic         mem_req;
  logic [63:0]  addr_in;
  logic         mem_done;
  logic [255:0] block;
  logic         bus_err;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [63:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  int errors;
  int checks;

  riscv_core_icache_axi_rd_master dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_mem_req  (mem_req),
    .i_addr     (addr_in),
    .o_mem_done (mem_done),
    .o_block    (block),
    .o_bus_err  (bus_err),
    .o_araddr   (araddr),
    .o_arlen    (arlen),
    .o_arsize   (arsize),
    .o_arburst  (arburst),
    .o_arvalid  (arvalid),
    .i_arready  (arready),
    .i_rdata    (rdata),
    .i_rresp    (rresp),
    .i_rlast    (rlast),
    .i_rvalid   (rvalid),
    .o_rready   (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Zero-latency slave model: drives AR ready after a stall, then beats base+k.
  task automatic do_refill(input logic [63:0] addr, input int ar_stall,
                           input logic [15:0] rv_pat, input int rv_len,
                           input int err_beat, input int last_beat,
                           input logic [63:0] base,
                           output int hs, output bit addr_moved,
                           output int cyc, output bit timed_out);
    int          stall_left;
    int          sent;
    int          ridx;
    bit          seen;
    logic [63:0] a0;
    stall_left = ar_stall;
    sent = 0; ridx = 0; seen = 1'b0; a0 = 64'd0;
    hs = 0; addr_moved = 1'b0; cyc = 0; timed_out = 1'b1;
    mem_req = 1'b1;
    addr_in = addr;
    for (int c = 0; c < 100; c++) begin
      tick();
      cyc++;
      if (mem_done) begin
        timed_out = 1'b0;
        break;
      end
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      if (arvalid) begin
        if (!seen) begin
          a0 = araddr;
          seen = 1'b1;
        end else if (araddr !== a0) begin
          addr_moved = 1'b1;
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          arready = 1'b1;
          hs++;
        end
      end else if (hs > 0) begin
        if ((sent <= last_beat) && ((ridx >= rv_len) || rv_pat[ridx])) begin
          rvalid = 1'b1;
          rdata  = base + 64'(sent);
          rresp  = (sent == err_beat) ? 2'b10 : 2'b00;
          rlast  = (sent == last_beat);
          sent++;
        end
        ridx++;
      end
    end
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic drop_req;
    mem_req = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mem_req = 1'b0; addr_in = 64'd0; arready = 1'b0;
    rdata = 64'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    #3;
    checks++;
    if ({arvalid, rready, mem_done, bus_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=0000", {arvalid, rready, mem_done, bus_err});
    end
    checks++;
    if ((block !== 256'd0) || (araddr !== 64'd0)) begin
      errors++;
      $display("FAIL reset_data block=%h araddr=%h exp=0", block, araddr);
    end
    checks++;
    if ({arlen, arsize, arburst} !== {8'd3, 3'd3, 2'b01}) begin
      errors++;
      $display("FAIL ar_const len=%0d size=%0d burst=%0d exp=3/3/1", arlen, arsize, arburst);
    end
    #14 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int hs; bit moved; int cyc; bit to;
    do_refill(64'h1000_0044, 0, 16'h0000, 0, -1, 3, 64'hA0, hs, moved, cyc, to);
    checks++;
    if (to || (cyc != 6)) begin
      errors++;
      $display("FAIL basic_latency got=%0d timeout=%0d exp=6", cyc, to);
    end
    checks++;
    if (araddr !== 64'h1000_0040) begin
      errors++;
      $display("FAIL basic_araddr got=%h exp=%h", araddr, 64'h1000_0040);
    end
    checks++;
    if (block !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin
      errors++;
      $display("FAIL basic_block got=%h", block);
    end
    checks++;
    if (bus_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_err got=%b exp=0", bus_err);
    end
    drop_req();
    checks++;
    if (mem_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_drop got=%b exp=0", mem_done);
    end
  endtask

  task automatic test_ar_stall;
    int hs; bit moved; int cyc; bit to;
    do_refill(64'h2000_0010, 5, 16'h0000, 0, -1, 3, 64'h1000, hs, moved, cyc, to);
    checks++;
    if (to || (cyc != 11) || (hs != 1) || moved) begin
      errors++;
      $display("FAIL stall_ar cyc=%0d hs=%0d moved=%0d to=%0d exp=11/1/0/0", cyc, hs, moved, to);
    end
    checks++;
    if ((araddr !== 64'h2000_0000) ||
        (block !== {64'h1003, 64'h1002, 64'h1001, 64'h1000})) begin
      errors++;
      $display("FAIL stall_line araddr=%h block=%h", araddr, block);
    end
    drop_req();
  endtask

  task automatic test_r_gaps;
    int hs; bit moved; int cyc; bit to;
    do_refill(64'h3000_003F, 0, 16'h0059, 7, -1, 3, 64'h2000, hs, moved, cyc, to);
    checks++;
    if (to || (cyc != 9)) begin
      errors++;
      $display("FAIL gaps_latency got=%0d timeout=%0d exp=9", cyc, to);
    end
    checks++;
    if ((block !== {64'h2003, 64'h2002, 64'h2001, 64'h2000}) || (bus_err !== 1'b0)) begin
      errors++;
      $display("FAIL gaps_block got=%h err=%b", block, bus_err);
    end
    drop_req();
  endtask

  task automatic test_err_resp;
    int hs; bit moved; int cyc; bit to;
    do_refill(64'h4000_0000, 0, 16'h0000, 0, 2, 3, 64'h3000, hs, moved, cyc, to);
    checks++;
    if (to || (bus_err !== 1'b1) ||
        (block !== {64'h3003, 64'h3002, 64'h3001, 64'h3000})) begin
      errors++;
      $display("FAIL err_resp err=%b block=%h to=%0d exp err=1", bus_err, block, to);
    end
    drop_req();
    do_refill(64'h4000_0020, 0, 16'h0000, 0, -1, 3, 64'h4000, hs, moved, cyc, to);
    checks++;
    if (to || (bus_err !== 1'b0) ||
        (block !== {64'h4003, 64'h4002, 64'h4001, 64'h4000})) begin
      errors++;
      $display("FAIL err_clear err=%b block=%h to=%0d exp err=0", bus_err, block, to);
    end
    drop_req();
  endtask

  task automatic test_early_rlast_handshake;
    int hs; bit moved; int cyc; bit to; int bad;
    do_refill(64'h5000_0008, 0, 16'h0000, 0, -1, 1, 64'h5000, hs, moved, cyc, to);
    checks++;
    if (to || (cyc != 4) || (bus_err !== 1'b1)) begin
      errors++;
      $display("FAIL early_rlast cyc=%0d err=%b to=%0d exp 4/1", cyc, bus_err, to);
    end
    checks++;
    if (block !== {64'h4003, 64'h4002, 64'h5001, 64'h5000}) begin
      errors++;
      $display("FAIL early_block got=%h", block);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ((mem_done !== 1'b1) || (arvalid !== 1'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL done_hold bad_cycles=%0d exp=0", bad);
    end
    drop_req();
    checks++;
    if ((mem_done !== 1'b0) || (block !== {64'h4003, 64'h4002, 64'h5001, 64'h5000})) begin
      errors++;
      $display("FAIL idle_keep done=%b block=%h", mem_done, block);
    end
  endtask

  task automatic test_reset_mid_burst;
    int hs; bit moved; int cyc; bit to;
    mem_req = 1'b1; addr_in = 64'h6000_0000;
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 64'h6000; rlast = 1'b0; rresp = 2'b00;
    tick();
    rdata = 64'h6001;
    tick();
    rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({arvalid, rready, mem_done} !== 3'b000 || (block !== 256'd0)) begin
      errors++;
      $display("FAIL mid_reset ctl=%b block=%h exp 000/0", {arvalid, rready, mem_done}, block);
    end
    mem_req = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    do_refill(64'h7000_0050, 0, 16'h0000, 0, -1, 3, 64'h7000, hs, moved, cyc, to);
    checks++;
    if (to || (cyc != 6) || (bus_err !== 1'b0) || (hs != 1) ||
        (block !== {64'h7003, 64'h7002, 64'h7001, 64'h7000})) begin
      errors++;
      $display("FAIL post_reset cyc=%0d hs=%0d err=%b block=%h", cyc, hs, bus_err, block);
    end
    drop_req();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_ar_stall();
    test_r_gaps();
    test_err_resp();
    test_early_rlast_handshake();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
